hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised successor to the 2-stage RAW forwarding logic in the rv32i pipeline.
//  Per decode-stage source operand it selects the nearest valid producer among NUM_FWD downstream stages.
//  It adds state: a per-register busy scoreboard for long-latency ops (mul/div/miss loads),
//  load-use / not-ready stall detection, an in-flight limit and a saturating stall-cycle counter.
//  Sits beside ID; fwd_sel drives the operand muxes, stall freezes PC/IF/ID and bubbles EX.
// PARAMETERS
//  NUM_SRC      2   source operands per instruction
//  NUM_FWD      2   forwarding stages; index 0 = nearest (EX), NUM_FWD-1 = farthest
//  NUM_REGS     32  architectural registers; register 0 hardwired zero
//  MAX_INFLIGHT 4   max outstanding long-latency ops (>=1)
//  WB_BYPASS    0   1: same-cycle lwb clear is visible to the busy check
//  Derived: AW=$clog2(NUM_REGS), SW=$clog2(NUM_FWD+1), CW=$clog2(MAX_INFLIGHT+1)
// PORTS
//  clk          in   1          clock
//  rst          in   1          asynchronous active-high reset
//  id_valid     in   1          valid instruction in ID
//  src_addr     in   NUM_SRC*AW source register per operand, operand i at [i*AW +: AW]
//  src_used     in   NUM_SRC    operand i actually read
//  fwd_rd       in   NUM_FWD*AW destination of stage k
//  fwd_we       in   NUM_FWD    stage k writes rd
//  fwd_ready    in   NUM_FWD    stage k result available (0 e.g. load in EX)
//  issue_long   in   1          ID instruction issues a long-latency op this cycle (gated by !stall)
//  issue_rd     in   AW         its destination
//  lwb_valid    in   1          long-latency op writes back this cycle
//  lwb_rd       in   AW         its destination
//  fwd_sel      out  NUM_SRC*SW 0 = regfile, k+1 = stage k
//  stall        out  1          hold ID
//  inflight     out  CW         outstanding long-latency ops
//  stall_cycles out  32         saturating count of stalled cycles
// BEHAVIOUR
//  Reset (async): busy[] = 0, inflight = 0, stall_cycles = 0.
//   Combinational outputs at reset: fwd_sel = 0 and stall = 0 unless inputs demand otherwise.
//  fwd_sel (comb): match_k = fwd_we[k] && fwd_rd[k]!=0 && fwd_rd[k]==src.
//   Lowest k wins (nearest producer). No match or src==0 -> 0.
//  Stall sources (comb; stall = id_valid && any source):
//   - Not ready: a used operand's winning stage has fwd_ready[k]=0.
//     Farther ready matches are ignored; they are stale.
//   - RAW busy: a used operand has busy[src]=1 and no stage match. Farther-stage forwarding never
//     masks busy; a match implies a short op superseded the long one.
//   - WAW: issue_long && busy[issue_rd].
//   - Capacity: issue_long && inflight==MAX_INFLIGHT && !lwb_valid.
//  Scoreboard (seq), accepted issue = issue_long && id_valid && !stall && issue_rd!=0:
//   - On accept: set busy[issue_rd].
//   - On lwb_valid: clear busy[lwb_rd].
//   - Same register in the same cycle: set wins.
//   - busy[0] always 0.
//  Latency: busy becomes visible the cycle after issue.
//   WB_BYPASS=0: stall releases the cycle after lwb.
//   WB_BYPASS=1: the lwb_rd clear applies to RAW/WAW checks the same cycle.
//  inflight: +1 on accept, -1 on lwb_valid, unchanged when both occur.
//   Never wraps; lwb with inflight==0 is ignored (assertion).
//  stall_cycles: +1 per stall cycle, saturates at 32'hFFFF_FFFF.
//  Reset mid-operation: all scoreboard state drops; pending lwb after reset only clears bits.
// TESTING
//  1. EX and MEM both write x5, ID reads x5 as rs1 -> fwd_sel[0]=1, stall=0.
//  2. EX load (fwd_ready[0]=0) rd=x7, ID reads x7 -> stall=1 for 1 cycle;
//     the next cycle MEM match gives sel=2 with stall=0. stall_cycles=1.
//  3. Issue div x9; next ID reads x9 -> stall until lwb_rd=9.
//     WB_BYPASS=0: release the cycle after lwb. WB_BYPASS=1: release on the lwb cycle.
//  4. MAX_INFLIGHT=4: issue 4 long ops to x1..x4, 5th issue -> stall=1, inflight=4.
//     An lwb that cycle -> 5th accepted, inflight stays 4.
//  5. Issue to x3 and lwb x3 same cycle with busy[3]=1 -> WAW stall.
//     With busy clear: accepted and busy[3]=1 next cycle (set wins).
//  6. Assert rst mid-stall with 3 in flight -> busy=0, inflight=0, stall_cycles=0 immediately;
//     writes to x0 never forward or set busy.

Source files
------------

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : ID-stage hazard unit. For every source operand it picks the
//             nearest valid producer among NUM_FWD downstream stages. It also
//             tracks a per-register busy scoreboard for long-latency ops and
//             raises a stall on not-ready producers, RAW-on-busy, WAW-on-busy
//             and in-flight capacity. A saturating counter records stalled
//             cycles.
//  Ports    : clk, rst          clock, asynchronous active-high reset
//             id_valid_i        valid instruction in ID
//             src_addr_i        source registers, operand i at [i*AW +: AW]
//             src_used_i        operand i actually read
//             fwd_rd_i/_we_i    destination / write enable of stage k
//             fwd_ready_i       stage k result available
//             issue_long_i/rd_i long-latency issue request and destination
//             lwb_valid_i/rd_i  long-latency write-back and destination
//             fwd_sel_o         0 = regfile, k+1 = stage k (per operand)
//             stall_o           hold ID
//             inflight_o        outstanding long-latency ops
//             stall_cycles_o    saturating count of stalled cycles
//  Notes    : NUM_REGS is expected to be a power of two.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NUM_SRC      = 2,
    parameter int NUM_FWD      = 2,
    parameter int NUM_REGS     = 32,
    parameter int MAX_INFLIGHT = 4,
    parameter int WB_BYPASS    = 0,
    localparam int AW = $clog2(NUM_REGS),
    localparam int SW = $clog2(NUM_FWD + 1),
    localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid_i,
    input  logic [NUM_SRC*AW-1:0] src_addr_i,
    input  logic [NUM_SRC-1:0]    src_used_i,
    input  logic [NUM_FWD*AW-1:0] fwd_rd_i,
    input  logic [NUM_FWD-1:0]    fwd_we_i,
    input  logic [NUM_FWD-1:0]    fwd_ready_i,
    input  logic                  issue_long_i,
    input  logic [AW-1:0]         issue_rd_i,
    input  logic                  lwb_valid_i,
    input  logic [AW-1:0]         lwb_rd_i,
    output logic [NUM_SRC*SW-1:0] fwd_sel_o,
    output logic                  stall_o,
    output logic [CW-1:0]         inflight_o,
    output logic [31:0]           stall_cycles_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] busy_vis;
    logic [CW-1:0]       inflight_q, inflight_d;
    logic [31:0]         stall_cycles_q, stall_cycles_d;

    logic [NUM_SRC-1:0]  src_not_ready;
    logic [NUM_SRC-1:0]  src_busy;
    logic                waw_hazard;
    logic                cap_hazard;
    logic                stall;
    logic                accept;
    logic                lwb_dec;

    // Busy view used by the hazard checks; with bypass enabled a write-back
    // this cycle already releases its register.
    always_comb begin
        busy_vis = busy_q;
        if (WB_BYPASS != 0 && lwb_valid_i) begin
            busy_vis[lwb_rd_i] = 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [AW-1:0] src;
        logic [SW-1:0] sel;
        logic          hit;
        logic          rdy;

        assign src = src_addr_i[i*AW +: AW];

        // Scan farthest to nearest so the nearest match overwrites: the
        // youngest producer is the only one holding the current value.
        always_comb begin
            sel = '0;
            hit = 1'b0;
            rdy = 1'b1;
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (fwd_we_i[k] && (fwd_rd_i[k*AW +: AW] != '0) &&
                    (fwd_rd_i[k*AW +: AW] == src)) begin
                    sel = SW'(k + 1);
                    hit = 1'b1;
                    rdy = fwd_ready_i[k];
                end
            end
        end

        assign fwd_sel_o[i*SW +: SW] = sel;
        assign src_not_ready[i]      = src_used_i[i] && hit && !rdy;
        // A pipeline match means a younger short op overwrote the register,
        // so the pending long result is no longer the one being read.
        assign src_busy[i]           = src_used_i[i] && !hit && busy_vis[src];
    end

    assign waw_hazard = issue_long_i && busy_vis[issue_rd_i];
    assign cap_hazard = issue_long_i && (inflight_q == CW'(MAX_INFLIGHT)) && !lwb_valid_i;
    assign stall      = id_valid_i &&
                        ((|src_not_ready) || (|src_busy) || waw_hazard || cap_hazard);
    assign accept     = issue_long_i && id_valid_i && !stall && (issue_rd_i != '0);
    // A write-back with nothing outstanding (e.g. left over from before a
    // reset) only clears bits and never underflows the counter.
    assign lwb_dec    = lwb_valid_i && (inflight_q != '0);

    always_comb begin
        busy_d = busy_q;
        if (lwb_valid_i) begin
            busy_d[lwb_rd_i] = 1'b0;
        end
        if (accept) begin
            busy_d[issue_rd_i] = 1'b1;   // set after clear: set wins
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        inflight_d = inflight_q;
        if (accept && !lwb_dec) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!accept && lwb_dec) begin
            inflight_d = inflight_q - CW'(1);
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q         <= '0;
            inflight_q     <= '0;
            stall_cycles_q <= '0;
        end else begin
            busy_q         <= busy_d;
            inflight_q     <= inflight_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_o        = stall;
    assign inflight_o     = inflight_q;
    assign stall_cycles_o = stall_cycles_q;

    a_lwb_outstanding: assert property (@(posedge clk) disable iff (rst)
        lwb_valid_i |-> (inflight_q != '0));

endmodule
`default_nettype wire
